// File: rtl/lstm_fwd_sequencer.sv
// Forward-pass control sequencer for the two-layer LSTM datapath: walks timesteps, then
// layer-1 and layer-2 cells, issuing registered read addresses and one-cycle write strobes.
module lstm_fwd_sequencer #(
    parameter int unsigned TIMESTEP   = 7,
    parameter int unsigned LAYR1_CELL = 2,
    parameter int unsigned LAYR2_CELL = 1,
    parameter int unsigned CELL_LAT   = 2,
    parameter int unsigned WIDTH      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] addr_x1,
    output logic [8:0]       rd_addr_h1,
    output logic [8:0]       rd_addr_h2,
    output logic [8:0]       rd_addr_c1,
    output logic [8:0]       rd_addr_c2,
    output logic [8:0]       rd_addr_x2,
    output logic [8:0]       wr_addr_h1,
    output logic [8:0]       wr_addr_c1,
    output logic [8:0]       wr_addr_h2,
    output logic [8:0]       wr_addr_c2,
    output logic [8:0]       wr_addr_x2,
    output logic             wr_h1,
    output logic             wr_c1,
    output logic             wr_x2,
    output logic             wr_h2,
    output logic             wr_c2,
    output logic [8:0]       sel_cell1,
    output logic [8:0]       sel_cell2,
    output logic             wr_layr1,
    output logic             wr_layr2
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StL1Rd = 3'd1;
    localparam logic [2:0] StL1Wr = 3'd2;
    localparam logic [2:0] StL2Rd = 3'd3;
    localparam logic [2:0] StL2Wr = 3'd4;
    localparam logic [2:0] StDone = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] t_q, t_d, j_q, j_d, w_q, w_d;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        j_d     = j_q;
        w_d     = w_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StL1Rd;
                    t_d     = 32'd0;
                    j_d     = 32'd0;
                    w_d     = 32'd0;
                end
            end
            StL1Rd, StL2Rd: begin
                if (w_q == CELL_LAT - 1) begin
                    state_d = (state_q == StL1Rd) ? StL1Wr : StL2Wr;
                    w_d     = 32'd0;
                end else begin
                    w_d = w_q + 32'd1;
                end
            end
            StL1Wr: begin
                w_d = 32'd0;
                if (j_q < LAYR1_CELL - 1) begin
                    j_d     = j_q + 32'd1;
                    state_d = StL1Rd;
                end else begin
                    j_d     = 32'd0;
                    state_d = StL2Rd;
                end
            end
            StL2Wr: begin
                w_d = 32'd0;
                if (j_q < LAYR2_CELL - 1) begin
                    j_d     = j_q + 32'd1;
                    state_d = StL2Rd;
                end else if (t_q < TIMESTEP - 1) begin
                    t_d     = t_q + 32'd1;
                    j_d     = 32'd0;
                    state_d = StL1Rd;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                t_d     = 32'd0;
                j_d     = 32'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so strobes align with the WR state cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            t_q        <= '0;
            j_q        <= '0;
            w_q        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_h1      <= 1'b0;
            wr_c1      <= 1'b0;
            wr_x2      <= 1'b0;
            wr_h2      <= 1'b0;
            wr_c2      <= 1'b0;
            addr_x1    <= '0;
            rd_addr_h1 <= '0;
            rd_addr_c1 <= '0;
            wr_addr_h1 <= '0;
            wr_addr_c1 <= '0;
            wr_addr_x2 <= '0;
            sel_cell1  <= '0;
            rd_addr_h2 <= '0;
            rd_addr_c2 <= '0;
            rd_addr_x2 <= '0;
            wr_addr_h2 <= '0;
            wr_addr_c2 <= '0;
            sel_cell2  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            j_q     <= j_d;
            w_q     <= w_d;
            busy    <= (state_d == StL1Rd) || (state_d == StL1Wr) ||
                       (state_d == StL2Rd) || (state_d == StL2Wr);
            done    <= (state_d == StDone);
            wr_h1   <= (state_d == StL1Wr);
            wr_c1   <= (state_d == StL1Wr);
            wr_x2   <= (state_d == StL1Wr);
            wr_h2   <= (state_d == StL2Wr);
            wr_c2   <= (state_d == StL2Wr);
            if (state_d == StL1Rd && state_q != StL1Rd) begin
                addr_x1    <= WIDTH'(t_d);
                rd_addr_h1 <= 9'(t_d);
                rd_addr_c1 <= 9'(t_d * LAYR1_CELL + j_d);
                wr_addr_h1 <= 9'((t_d + 32'd1) * LAYR1_CELL + j_d);
                wr_addr_c1 <= 9'((t_d + 32'd1) * LAYR1_CELL + j_d);
                wr_addr_x2 <= 9'(t_d * LAYR1_CELL + j_d);
                sel_cell1  <= 9'(j_d);
            end
            if (state_d == StL2Rd && state_q != StL2Rd) begin
                rd_addr_h2 <= 9'(t_d);
                rd_addr_c2 <= 9'(t_d * LAYR2_CELL + j_d);
                rd_addr_x2 <= 9'(t_d);
                wr_addr_h2 <= 9'((t_d + 32'd1) * LAYR2_CELL + j_d);
                wr_addr_c2 <= 9'((t_d + 32'd1) * LAYR2_CELL + j_d);
                sel_cell2  <= 9'(j_d);
            end
        end
    end

    // Forward-only sequencer: weight memories are never written.
    assign wr_layr1 = 1'b0;
    assign wr_layr2 = 1'b0;

endmodule

// File: tb/tb_lstm_fwd_sequencer.sv
// Directed bench for lstm_fwd_sequencer: default instance plus a small-parameter variant.
module tb_lstm_fwd_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;

    logic        busy, done, wr_h1, wr_c1, wr_x2, wr_h2, wr_c2, wr_layr1, wr_layr2;
    logic [31:0] addr_x1;
    logic [8:0]  rd_addr_h1, rd_addr_h2, rd_addr_c1, rd_addr_c2, rd_addr_x2;
    logic [8:0]  wr_addr_h1, wr_addr_c1, wr_addr_h2, wr_addr_c2, wr_addr_x2;
    logic [8:0]  sel_cell1, sel_cell2;

    logic        busy2, done2, wr_h1_2, wr_c1_2, wr_x2_2, wr_h2_2, wr_c2_2;
    logic        wr_layr1_2, wr_layr2_2;
    logic [31:0] addr_x1_2;
    logic [8:0]  rd_addr_h1_2, rd_addr_h2_2, rd_addr_c1_2, rd_addr_c2_2, rd_addr_x2_2;
    logic [8:0]  wr_addr_h1_2, wr_addr_c1_2, wr_addr_h2_2, wr_addr_c2_2, wr_addr_x2_2;
    logic [8:0]  sel_cell1_2, sel_cell2_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lstm_fwd_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .addr_x1(addr_x1),
        .rd_addr_h1(rd_addr_h1), .rd_addr_h2(rd_addr_h2), .rd_addr_c1(rd_addr_c1),
        .rd_addr_c2(rd_addr_c2), .rd_addr_x2(rd_addr_x2), .wr_addr_h1(wr_addr_h1),
        .wr_addr_c1(wr_addr_c1), .wr_addr_h2(wr_addr_h2), .wr_addr_c2(wr_addr_c2),
        .wr_addr_x2(wr_addr_x2), .wr_h1(wr_h1), .wr_c1(wr_c1), .wr_x2(wr_x2), .wr_h2(wr_h2),
        .wr_c2(wr_c2), .sel_cell1(sel_cell1), .sel_cell2(sel_cell2), .wr_layr1(wr_layr1),
        .wr_layr2(wr_layr2)
    );

    lstm_fwd_sequencer #(
        .TIMESTEP(2), .LAYR1_CELL(3), .LAYR2_CELL(2), .CELL_LAT(1), .WIDTH(32)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .addr_x1(addr_x1_2),
        .rd_addr_h1(rd_addr_h1_2), .rd_addr_h2(rd_addr_h2_2), .rd_addr_c1(rd_addr_c1_2),
        .rd_addr_c2(rd_addr_c2_2), .rd_addr_x2(rd_addr_x2_2), .wr_addr_h1(wr_addr_h1_2),
        .wr_addr_c1(wr_addr_c1_2), .wr_addr_h2(wr_addr_h2_2), .wr_addr_c2(wr_addr_c2_2),
        .wr_addr_x2(wr_addr_x2_2), .wr_h1(wr_h1_2), .wr_c1(wr_c1_2), .wr_x2(wr_x2_2),
        .wr_h2(wr_h2_2), .wr_c2(wr_c2_2), .sel_cell1(sel_cell1_2), .sel_cell2(sel_cell2_2),
        .wr_layr1(wr_layr1_2), .wr_layr2(wr_layr2_2)
    );

    typedef struct {
        int          cyc;
        logic        busy, done, h1, h2;
        logic [8:0]  wa_h1, wa_c1, wa_h2;
        logic [31:0] ax1;
        logic [8:0]  rc1, wax2, sel1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_busy, n_done, n_h1, n_c1, n_x2, n_h2, n_c2;

        //           cyc busy done h1 h2 wa_h1 wa_c1 wa_h2 ax1 rc1 wax2 sel1
        vecs.push_back('{0,  1, 0, 0, 0, 2,  2,  0, 0, 0,  0,  0});
        vecs.push_back('{2,  1, 0, 1, 0, 2,  2,  0, 0, 0,  0,  0});
        vecs.push_back('{3,  1, 0, 0, 0, 3,  3,  0, 0, 1,  1,  1});
        vecs.push_back('{5,  1, 0, 1, 0, 3,  3,  0, 0, 1,  1,  1});
        vecs.push_back('{6,  1, 0, 0, 0, 3,  3,  1, 0, 1,  1,  1});
        vecs.push_back('{8,  1, 0, 0, 1, 3,  3,  1, 0, 1,  1,  1});
        vecs.push_back('{9,  1, 0, 0, 0, 4,  4,  1, 1, 2,  2,  0});
        vecs.push_back('{29, 1, 0, 1, 0, 8,  8,  3, 3, 6,  6,  0});
        vecs.push_back('{30, 1, 0, 0, 0, 9,  9,  3, 3, 7,  7,  1});
        vecs.push_back('{31, 1, 0, 0, 0, 9,  9,  3, 3, 7,  7,  1});
        vecs.push_back('{32, 1, 0, 1, 0, 9,  9,  3, 3, 7,  7,  1});
        vecs.push_back('{62, 1, 0, 0, 1, 15, 15, 7, 6, 13, 13, 1});
        vecs.push_back('{63, 0, 1, 0, 0, 15, 15, 7, 6, 13, 13, 1});
        vecs.push_back('{64, 0, 0, 0, 0, 15, 15, 7, 6, 13, 13, 1});

        // Reset and idle
        repeat (2) @(negedge clk);
        check("rst busy/done", {busy, done}, 0);
        check("rst strobes", {wr_h1, wr_c1, wr_x2, wr_h2, wr_c2, wr_layr1, wr_layr2}, 0);
        check("rst addr_x1", addr_x1, 0);
        check("rst wr addrs", {wr_addr_h1, wr_addr_c1, wr_addr_h2, wr_addr_c2, wr_addr_x2}, 0);
        check("rst rd addrs", {rd_addr_h1, rd_addr_c1, rd_addr_h2, rd_addr_c2}, 0);
        check("rst rd_x2/sel", {rd_addr_x2, sel_cell1, sel_cell2}, 0);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("idle c%0d", c),
                  {busy, done, wr_h1, wr_c1, wr_x2, wr_h2, wr_c2, busy2, done2}, 0);
        end

        // Full default run
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_busy = 0; n_done = 0; n_h1 = 0; n_c1 = 0; n_x2 = 0; n_h2 = 0; n_c2 = 0;
        for (int c = 0; c < 66; c++) begin
            foreach (vecs[i]) begin
                if (vecs[i].cyc == c) begin
                    check($sformatf("c%0d busy", c), busy, vecs[i].busy);
                    check($sformatf("c%0d done", c), done, vecs[i].done);
                    check($sformatf("c%0d wr_h1", c), wr_h1, vecs[i].h1);
                    check($sformatf("c%0d wr_h2", c), wr_h2, vecs[i].h2);
                    check($sformatf("c%0d wr_addr_h1", c), wr_addr_h1, vecs[i].wa_h1);
                    check($sformatf("c%0d wr_addr_c1", c), wr_addr_c1, vecs[i].wa_c1);
                    check($sformatf("c%0d wr_addr_h2", c), wr_addr_h2, vecs[i].wa_h2);
                    check($sformatf("c%0d addr_x1", c), addr_x1, vecs[i].ax1);
                    check($sformatf("c%0d rd_addr_c1", c), rd_addr_c1, vecs[i].rc1);
                    check($sformatf("c%0d wr_addr_x2", c), wr_addr_x2, vecs[i].wax2);
                    check($sformatf("c%0d sel_cell1", c), sel_cell1, vecs[i].sel1);
                end
            end
            check($sformatf("c%0d group overlap", c), 32'((wr_h1 | wr_c1 | wr_x2) &
                  (wr_h2 | wr_c2)), 0);
            check($sformatf("c%0d wr_layr", c), {wr_layr1, wr_layr2}, 0);
            if (wr_h1) begin
                check($sformatf("h1 seq %0d", n_h1), wr_addr_h1, 32'(2 + n_h1));
                check($sformatf("rd_addr_h1 %0d", n_h1), rd_addr_h1, 32'(n_h1 / 2));
            end
            if (wr_x2) check($sformatf("x2 seq %0d", n_x2), wr_addr_x2, 32'(n_x2));
            if (wr_h2) begin
                check($sformatf("h2 seq %0d", n_h2), wr_addr_h2, 32'(1 + n_h2));
                check($sformatf("c2 seq %0d", n_h2), wr_addr_c2, 32'(1 + n_h2));
                check($sformatf("rd_addr_h2 %0d", n_h2), rd_addr_h2, 32'(n_h2));
                check($sformatf("rd_addr_c2 %0d", n_h2), rd_addr_c2, 32'(n_h2));
                check($sformatf("rd_addr_x2 %0d", n_h2), rd_addr_x2, 32'(n_h2));
                check($sformatf("sel_cell2 %0d", n_h2), sel_cell2, 0);
            end
            n_busy += 32'(busy); n_done += 32'(done);
            n_h1 += 32'(wr_h1); n_c1 += 32'(wr_c1); n_x2 += 32'(wr_x2);
            n_h2 += 32'(wr_h2); n_c2 += 32'(wr_c2);
            @(negedge clk);
        end
        check("busy cycles", n_busy, 63);
        check("done pulses", n_done, 1);
        check("wr_h1 count", n_h1, 14);
        check("wr_c1 count", n_c1, 14);
        check("wr_x2 count", n_x2, 14);
        check("wr_h2 count", n_h2, 7);
        check("wr_c2 count", n_c2, 7);

        // start held high: one run, then restart after returning to idle
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        n_done = 0; n_h1 = 0;
        for (int c = 0; c < 68; c++) begin
            if (c < 65) begin
                n_done += 32'(done);
                n_h1 += 32'(wr_h1);
            end
            if (c == 63) begin
                check("held done", done, 1);
                check("held done strobes", {wr_h1, wr_c1, wr_x2, wr_h2, wr_c2}, 0);
            end
            if (c == 64) check("held idle gap", {busy, done}, 0);
            if (c == 65) check("held rerun busy", busy, 1);
            if (c == 67) begin
                check("held rerun wr_h1", wr_h1, 1);
                check("held rerun wr_addr_h1", wr_addr_h1, 2);
            end
            @(negedge clk);
        end
        check("held single done", n_done, 1);
        check("held single run h1", n_h1, 14);
        start = 1'b0;
        wait_done("held second done");

        // Reset mid-run in an L1_WR cycle at t=2
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid wr_h1 before", wr_h1, 1);
        check("mid wr_addr_h1 before", wr_addr_h1, 6);
        rst = 1'b0;
        #1;
        check("mid rst strobes", {wr_h1, wr_c1, wr_x2, wr_h2, wr_c2}, 0);
        check("mid rst busy/done", {busy, done}, 0);
        check("mid rst addr_x1", addr_x1, 0);
        check("mid rst wr addrs", {wr_addr_h1, wr_addr_c1, wr_addr_h2, wr_addr_x2}, 0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        check("restart wr_h1", wr_h1, 1);
        check("restart wr_addr_h1", wr_addr_h1, 2);
        check("restart addr_x1", addr_x1, 0);
        wait_done("restart done");

        // Variant: TIMESTEP=2, LAYR1_CELL=3, LAYR2_CELL=2, CELL_LAT=1
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        n_h1 = 0; n_h2 = 0;
        for (int c = 0; c < 23; c++) begin
            logic wcyc, l1;
            wcyc = (c < 20) && (c % 2 == 1);
            l1   = (((c - 1) / 2) % 5) < 3;
            check($sformatf("v c%0d wr_h1", c), wr_h1_2, 32'(wcyc && l1));
            check($sformatf("v c%0d wr_h2", c), wr_h2_2, 32'(wcyc && !l1));
            check($sformatf("v c%0d busy", c), busy2, 32'(c < 20));
            check($sformatf("v c%0d done", c), done2, 32'(c == 20));
            check($sformatf("v c%0d wr_layr", c), {wr_layr1_2, wr_layr2_2}, 0);
            if (wr_h1_2) check($sformatf("v h1 seq %0d", n_h1), wr_addr_h1_2, 32'(3 + n_h1));
            if (wr_h2_2) check($sformatf("v h2 seq %0d", n_h2), wr_addr_h2_2, 32'(2 + n_h2));
            n_h1 += 32'(wr_h1_2);
            n_h2 += 32'(wr_h2_2);
            @(negedge clk);
        end
        check("v wr_h1 count", n_h1, 6);
        check("v wr_h2 count", n_h2, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
